// File: rtl/reg32_byte_reader.sv
// Streams selected byte lanes of a captured 32-bit word over a valid/ready handshake.
// Optional per-byte parity output is enabled by defining REG32_RD_PARITY_EN.
module reg32_byte_reader #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  lanemask,
  input  logic [31:0] D,
  input  logic        byte_ready,
  output logic        byte_valid,
  output logic [7:0]  byte_out,
  output logic [1:0]  byte_lane,
  output logic        last,
  output logic        busy,
  output logic        done
`ifdef REG32_RD_PARITY_EN
  ,
  output logic        byte_parity
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] shadow_q, shadow_d;
  logic [3:0]  pend_q, pend_d;
  logic        valid_q, valid_d;
  logic [7:0]  byte_q, byte_d;
  logic [1:0]  lane_q, lane_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        parity_q, parity_d;

  logic [3:0]  rem_mask;
  logic [3:0]  mask_sel;
  logic [31:0] word_sel;
  logic [1:0]  sel_lane;
  logic [7:0]  sel_byte;
  logic        sel_last;

  // First pending lane in visit order: lowest set bit, or highest when MSB_FIRST.
  function automatic logic [1:0] pick_lane(input logic [3:0] m);
    logic [1:0] l;
    l = 2'd0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 4; i++)
        if (m[i]) l = 2'(i);
    end else begin
      for (int i = 3; i >= 0; i--)
        if (m[i]) l = 2'(i);
    end
    return l;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    logic [7:0] b;
    case (l)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // In IDLE the first lane comes straight from the inputs so it is valid one cycle after start.
  assign rem_mask = pend_q & ~(4'b0001 << lane_q);
  assign mask_sel = (state_q == S_IDLE) ? lanemask : rem_mask;
  assign word_sel = (state_q == S_IDLE) ? D : shadow_q;
  assign sel_lane = pick_lane(mask_sel);
  assign sel_byte = lane_byte(word_sel, sel_lane);
  assign sel_last = ((mask_sel & ~(4'b0001 << sel_lane)) == 4'b0000);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    valid_d  = valid_q;
    byte_d   = byte_q;
    lane_d   = lane_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (lanemask != 4'b0000) begin
            state_d  = S_SEND;
            shadow_d = D;
            pend_d   = lanemask;
            valid_d  = 1'b1;
            byte_d   = sel_byte;
            lane_d   = sel_lane;
            last_d   = sel_last;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (valid_q && byte_ready) begin
          pend_d = rem_mask;
          if (rem_mask == 4'b0000) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            byte_d  = 8'h00;
            lane_d  = 2'd0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            byte_d = sel_byte;
            lane_d = sel_lane;
            last_d = sel_last;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    parity_d = ^byte_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shadow_q <= 32'h0;
      pend_q   <= 4'h0;
      valid_q  <= 1'b0;
      byte_q   <= 8'h00;
      lane_q   <= 2'd0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      byte_q   <= byte_d;
      lane_q   <= lane_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      parity_q <= parity_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_out   = byte_q;
  assign byte_lane  = lane_q;
  assign last       = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef REG32_RD_PARITY_EN
  assign byte_parity = parity_q;
`else
  logic unused_parity;
  assign unused_parity = parity_q;
`endif

endmodule
